// File: rtl/wb_pkg.sv
// Shared constants for the write-back stage: load-size codes and default
// link-register parameters.
package wb_pkg;

  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10
  } load_size_e;

  localparam int DEF_LINK_REG    = 31;
  localparam int DEF_LINK_OFFSET = 8;

endpackage

// File: rtl/wb_stage_pipelined_if.sv
// MEM/WB bundle plus register-file write port and debug outputs of the
// write-back stage; master drives the bundle, slave is the stage.
interface wb_stage_pipelined_if #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_PC   = 32,
  parameter int NB_CNT  = 32
);
  logic               i_enable;
  logic               i_flush;
  logic               i_valid;
  logic               i_WB_reg_write;
  logic               i_WB_mem_to_reg;
  logic               i_WB_last_register_ctrl;
  logic [1:0]         i_load_size;
  logic               i_load_unsigned;
  logic [1:0]         i_byte_offset;
  logic [NB_DATA-1:0] i_WB_mem_data;
  logic [NB_DATA-1:0] i_WB_alu_result;
  logic [NB_REG-1:0]  i_WB_selected_reg;
  logic [NB_PC-1:0]   i_pc;
  logic               i_halt;
  logic               o_WB_reg_write;
  logic [NB_DATA-1:0] o_WB_selected_data;
  logic [NB_REG-1:0]  o_WB_selected_reg;
  logic [NB_CNT-1:0]  o_retired_count;
  logic               o_halted;

  modport master (
    output i_enable, i_flush, i_valid, i_WB_reg_write, i_WB_mem_to_reg,
           i_WB_last_register_ctrl, i_load_size, i_load_unsigned, i_byte_offset,
           i_WB_mem_data, i_WB_alu_result, i_WB_selected_reg, i_pc, i_halt,
    input  o_WB_reg_write, o_WB_selected_data, o_WB_selected_reg,
           o_retired_count, o_halted
  );

  modport slave (
    input  i_enable, i_flush, i_valid, i_WB_reg_write, i_WB_mem_to_reg,
           i_WB_last_register_ctrl, i_load_size, i_load_unsigned, i_byte_offset,
           i_WB_mem_data, i_WB_alu_result, i_WB_selected_reg, i_pc, i_halt,
    output o_WB_reg_write, o_WB_selected_data, o_WB_selected_reg,
           o_retired_count, o_halted
  );
endinterface

// File: rtl/wb_load_extract.sv
// Combinational little-endian load alignment: picks the byte/half lane from the
// raw memory word and sign- or zero-extends it to the data path width.
module wb_load_extract
  import wb_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] mem_data,
  input  logic [1:0]         load_size,
  input  logic               load_unsigned,
  input  logic [1:0]         byte_offset,
  output logic [NB_DATA-1:0] ext_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        fill_s;

  // Lane selection and extension; offset[0] is irrelevant for halves
  always_comb begin
    byte_s   = 8'h00;
    half_s   = 16'h0000;
    fill_s   = 1'b0;
    ext_data = mem_data;
    case (byte_offset)
      2'b00:   byte_s = mem_data[7:0];
      2'b01:   byte_s = mem_data[15:8];
      2'b10:   byte_s = mem_data[23:16];
      2'b11:   byte_s = mem_data[31:24];
      default: byte_s = mem_data[7:0];
    endcase
    if (byte_offset[1]) begin
      half_s = mem_data[31:16];
    end else begin
      half_s = mem_data[15:0];
    end
    case (load_size)
      LD_BYTE: begin
        fill_s   = ~load_unsigned & byte_s[7];
        ext_data = {{(NB_DATA-8){fill_s}}, byte_s};
      end
      LD_HALF: begin
        fill_s   = ~load_unsigned & half_s[15];
        ext_data = {{(NB_DATA-16){fill_s}}, half_s};
      end
      default: ext_data = mem_data;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipelined.sv
// Registered MIPS write-back stage: selects link/load/ALU data, drives the
// register-file write port, counts retired instructions and latches HALT.
module wb_stage_pipelined
  import wb_pkg::*;
#(
  parameter int NB_DATA     = 32,
  parameter int NB_REG      = 5,
  parameter int NB_PC       = 32,
  parameter int NB_CNT      = 32,
  parameter int LINK_REG    = DEF_LINK_REG,
  parameter int LINK_OFFSET = DEF_LINK_OFFSET
) (
  input logic                 i_clock,
  input logic                 i_reset,
  wb_stage_pipelined_if.slave bus
);

  logic [NB_DATA-1:0] load_data_s;
  logic [NB_DATA-1:0] sel_data_s;
  logic [NB_PC-1:0]   link_pc_s;
  logic [NB_REG-1:0]  sel_reg_s;
  logic               we_s;

  logic               we_r;
  logic [NB_DATA-1:0] data_r;
  logic [NB_REG-1:0]  reg_r;
  logic [NB_CNT-1:0]  cnt_r;
  logic               halted_r;

  wb_load_extract #(.NB_DATA(NB_DATA)) u_load_extract (
    .mem_data      (bus.i_WB_mem_data),
    .load_size     (bus.i_load_size),
    .load_unsigned (bus.i_load_unsigned),
    .byte_offset   (bus.i_byte_offset),
    .ext_data      (load_data_s)
  );

  // Data/destination select (link > load > ALU) and r0-suppressed write enable
  always_comb begin
    link_pc_s = bus.i_pc + NB_PC'(LINK_OFFSET);
    if (bus.i_WB_last_register_ctrl) begin
      sel_data_s = NB_DATA'(link_pc_s);
      sel_reg_s  = NB_REG'(LINK_REG);
    end else if (bus.i_WB_mem_to_reg) begin
      sel_data_s = load_data_s;
      sel_reg_s  = bus.i_WB_selected_reg;
    end else begin
      sel_data_s = bus.i_WB_alu_result;
      sel_reg_s  = bus.i_WB_selected_reg;
    end
    we_s = bus.i_WB_reg_write & bus.i_valid & (sel_reg_s != {NB_REG{1'b0}});
  end

  // Stage register; a latched HALT freezes everything until reset
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      we_r     <= 1'b0;
      data_r   <= {NB_DATA{1'b0}};
      reg_r    <= {NB_REG{1'b0}};
      cnt_r    <= {NB_CNT{1'b0}};
      halted_r <= 1'b0;
    end else if (!halted_r) begin
      if (bus.i_flush) begin
        we_r   <= 1'b0;
        data_r <= {NB_DATA{1'b0}};
        reg_r  <= {NB_REG{1'b0}};
      end else if (bus.i_enable) begin
        we_r   <= we_s;
        data_r <= sel_data_s;
        reg_r  <= sel_reg_s;
        if (bus.i_valid) begin
          cnt_r <= cnt_r + NB_CNT'(1);
          if (bus.i_halt) begin
            halted_r <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.o_WB_reg_write     = we_r;
  assign bus.o_WB_selected_data = data_r;
  assign bus.o_WB_selected_reg  = reg_r;
  assign bus.o_retired_count    = cnt_r;
  assign bus.o_halted           = halted_r;

endmodule
